// File: rtl/comb_pipe.sv
// Elastic valid/ready pipeline carrying pass-through, compare-select, 3-bit lookup and modular-sum results.
// Optional occupancy counter port `occ` is enabled by defining COMB_PIPE_OCC_EN.
module comb_pipe #(
   parameter int size  = 1,
   parameter int depth = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [size-1:0] src1,
   input  logic [size-1:0] src2,
   input  logic [size-1:0] src3,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [size-1:0] out1,
   output logic [size-1:0] out2,
   output logic [size-1:0] out3,
   output logic [size-1:0] out4
`ifdef COMB_PIPE_OCC_EN
   ,output logic [3:0]     occ
`endif
);

   localparam int W = 4 * size;

   logic [size-1:0] f1, f2, f3, f4;
   logic            ready [depth+1];

   always_comb begin
      f1 = src1;
      f2 = (src1 < src2) ? src1 : src3;
      f4 = src1 + src2;
   end

   // 7 - {src1[0], src2[0], src3[0]} is simply the bitwise inverse of those three bits.
   for (genvar gi = 0; gi < size; gi++) begin : g_lut
      if (gi == 0) begin : g_b0
         assign f3[gi] = ~src3[0];
      end else if (gi == 1) begin : g_b1
         assign f3[gi] = ~src2[0];
      end else if (gi == 2) begin : g_b2
         assign f3[gi] = ~src1[0];
      end else begin : g_bz
         assign f3[gi] = 1'b0;
      end
   end

   assign ready[depth] = out_ready;

   for (genvar gi = 0; gi < depth; gi++) begin : g_stage
      logic          stage_valid;
      logic [W-1:0]  stage_data;
      logic          up_valid;
      logic [W-1:0]  up_data;

      if (gi == 0) begin : g_head
         assign up_valid = in_valid;
         assign up_data  = {f1, f2, f3, f4};
      end else begin : g_body
         assign up_valid = g_stage[gi-1].stage_valid;
         assign up_data  = g_stage[gi-1].stage_data;
      end

      // A stage may load when empty or when its occupant moves on this cycle.
      assign ready[gi] = !stage_valid | ready[gi+1];

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            stage_valid <= 1'b0;
            stage_data  <= '0;
         end else if (ready[gi]) begin
            stage_valid <= up_valid;
            stage_data  <= up_data;
         end
      end
   end

   assign in_ready  = ready[0];
   assign out_valid = g_stage[depth-1].stage_valid;
   assign out1      = g_stage[depth-1].stage_data[4*size-1 -: size];
   assign out2      = g_stage[depth-1].stage_data[3*size-1 -: size];
   assign out3      = g_stage[depth-1].stage_data[2*size-1 -: size];
   assign out4      = g_stage[depth-1].stage_data[size-1 -: size];

`ifdef COMB_PIPE_OCC_EN
   logic accept, drain;

   assign accept = in_valid & ready[0];
   assign drain  = out_valid & out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         occ <= 4'd0;
      end else begin
         case ({accept, drain})
            2'b10:   occ <= occ + 4'd1;
            2'b01:   occ <= occ - 4'd1;
            default: occ <= occ;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_comb_pipe.sv
// Scoreboard bench for comb_pipe (size=4, depth=3): directed words with hand-computed results.
module tb_comb_pipe;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] src1, src2, src3;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out1, out2, out3, out4;
`ifdef COMB_PIPE_OCC_EN
   logic [3:0] occ;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   logic [15:0] cur_exp;
   logic [15:0] exp_q [$];

   comb_pipe #(.size(4), .depth(3)) dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .src1(src1),
      .src2(src2),
      .src3(src3),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out1(out1),
      .out2(out2),
      .out3(out3),
      .out4(out4)
`ifdef COMB_PIPE_OCC_EN
      ,.occ(occ)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end else begin
         $display("ok   %s: %0h at %0t", name, act, $time);
      end
   endtask

   task automatic check_occ(input string name, input logic [3:0] exp);
`ifdef COMB_PIPE_OCC_EN
      check(name, {28'd0, occ}, {28'd0, exp});
`else
      if (exp === 4'hx) $display("never");
`endif
   endtask

   // expected word layout: {out1, out2, out3, out4}
   task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic [15:0] e);
      src1 = a; src2 = b; src3 = c; cur_exp = e; in_valid = 1'b1;
   endtask

   // Expectation is recorded on the cycle a word is actually accepted.
   always @(negedge clk) begin
      if (!reset && in_valid && in_ready)
         exp_q.push_back(cur_exp);
   end

   // Monitor: every output transfer is compared against the oldest expectation.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL out_unexpected: got %0h expected none at %0t", {out1, out2, out3, out4}, $time);
         end else begin
            check("out_data", {16'd0, out1, out2, out3, out4}, {16'd0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset with arbitrary inputs
      reset = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
      src1 = 4'ha; src2 = 4'h5; src3 = 4'hc; cur_exp = 16'h0;
      repeat (2) @(negedge clk);
      check("rst_valid", {31'd0, out_valid}, 0);
      check("rst_data", {16'd0, out1, out2, out3, out4}, 0);
      check("rst_ready", {31'd0, in_ready}, 1);
      check_occ("rst_occ", 4'd0);
      @(posedge clk); #1;
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("idle_valid", {31'd0, out_valid}, 0);
      end

      // single word: 3,5,9 -> 3,3,0,8 visible only after edge 2
      @(posedge clk); #1;
      drive(4'd3, 4'd5, 4'd9, 16'h3308);
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("lat_valid", {31'd0, out_valid}, (k == 2) ? 1 : 0);
      end

      // select/wrap: 12,7,6 -> c,6,(7-3'b010)=5,19 mod 16=3
      @(posedge clk); #1;
      drive(4'd12, 4'd7, 4'd6, 16'hC653);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(negedge clk);

      // back-pressure: A..C fill the pipe, D waits
      @(posedge clk); #1;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         case (i)
            0:       drive(4'd1, 4'd2, 4'd3, 16'h1123);
            1:       drive(4'd2, 4'd1, 4'd4, 16'h2453);
            default: drive(4'd15, 4'd15, 4'd0, 16'hF01E);
         endcase
         @(negedge clk);
         check("bp_accept", {31'd0, in_ready}, 1);
         @(posedge clk); #1;
         check_occ("bp_occ", 4'(i + 1));
      end
      drive(4'd0, 4'd15, 4'd7, 16'h004F);
      repeat (3) begin
         @(negedge clk);
         check("full_ready", {31'd0, in_ready}, 0);
         check("full_valid", {31'd0, out_valid}, 1);
         check("full_hold", {28'd0, out1}, 1);
         check_occ("full_occ", 4'd3);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      check("drain_ready", {31'd0, in_ready}, 1);
      @(posedge clk); #1;
      drive(4'd9, 4'd10, 4'd11, 16'h9923);
      @(negedge clk);
      check("gap_valid", {31'd0, out_valid}, 1);
      check_occ("occ_both", 4'd3);
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("gap_valid", {31'd0, out_valid}, 1);
         check_occ("drain_occ", 4'(3 - i));
      end
      @(negedge clk);
      check("empty_valid", {31'd0, out_valid}, 0);
      check_occ("empty_occ", 4'd0);

      // reset mid-stream
      @(posedge clk); #1;
      drive(4'd1, 4'd2, 4'd3, 16'h1123);
      @(posedge clk); #1;
      drive(4'd2, 4'd1, 4'd4, 16'h2453);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("pre_rst_valid", {31'd0, out_valid}, 1);
      reset = 1'b1;
      #1;
      check("mid_rst_valid", {31'd0, out_valid}, 0);
      check("mid_rst_data", {16'd0, out1, out2, out3, out4}, 0);
      check("mid_rst_ready", {31'd0, in_ready}, 1);
      check_occ("mid_rst_occ", 4'd0);
      exp_q.delete();
      #1;
      reset = 1'b0;
      @(posedge clk); #1;
      drive(4'd14, 4'd3, 4'd1, 16'hE141);
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("rst_lat_valid", {31'd0, out_valid}, (k == 2) ? 1 : 0);
      end

      repeat (2) @(negedge clk);
      check("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
